// File: rtl/sample_stream_tx_if.sv
// Valid/ready sample stream feeding the tap-line transmitter.
// The source drives master; the transmitter takes slave.
interface sample_stream_tx_if #(
    parameter int BITS_PER_TAP = 8
);
    logic signed [BITS_PER_TAP-1:0] i_value;
    logic                           i_valid;
    logic                           o_ready;

    modport master (
        output i_value,
        output i_valid,
        input  o_ready
    );

    modport slave (
        input  i_value,
        input  i_valid,
        output o_ready
    );
endinterface

// File: rtl/sample_stream_tx.sv
// Tap-line sample transmitter: a small FIFO fed by a valid/ready source, replayed onto
// o_value with a paced capture strobe o_data_clk (SETUP low, HIGH high, LOW low).
module sample_stream_tx #(
    parameter int BITS_PER_TAP = 8,
    parameter int FIFO_DEPTH   = 4,
    parameter int SETUP_CYCLES = 2,
    parameter int HIGH_CYCLES  = 2,
    parameter int LOW_CYCLES   = 3
) (
    input  logic                           clk,
    input  logic                           rst,
    sample_stream_tx_if.slave              s_if,
    output logic signed [BITS_PER_TAP-1:0] o_value,
    output logic                           o_data_clk,
    output logic                           o_busy,
    output logic [15:0]                    o_sent_count
);

    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int MAX_A = (SETUP_CYCLES > HIGH_CYCLES) ? SETUP_CYCLES : HIGH_CYCLES;
    localparam int MAXC  = (MAX_A > LOW_CYCLES) ? MAX_A : LOW_CYCLES;
    localparam int CW    = (MAXC > 1) ? $clog2(MAXC) : 1;

    if (SETUP_CYCLES + LOW_CYCLES < 3) begin : g_bad_low_time
        $error("sample_stream_tx: SETUP_CYCLES+LOW_CYCLES must be >= 3");
    end
    if (FIFO_DEPTH < 2 || (1 << AW) != FIFO_DEPTH) begin : g_bad_depth
        $error("sample_stream_tx: FIFO_DEPTH must be a power of 2 and >= 2");
    end
    if (SETUP_CYCLES < 1 || HIGH_CYCLES < 1 || LOW_CYCLES < 1) begin : g_bad_phase
        $error("sample_stream_tx: every phase length must be >= 1");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_HIGH,
        S_LOW
    } state_e;

    // ---------------- input FIFO ----------------
    logic [BITS_PER_TAP-1:0] mem_q [FIFO_DEPTH];
    logic [AW:0]             wr_ptr_q, wr_ptr_d;
    logic [AW:0]             rd_ptr_q, rd_ptr_d;
    logic                    full;
    logic                    empty;
    logic                    push;
    logic                    pop;
    logic [BITS_PER_TAP-1:0] head;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign head  = mem_q[rd_ptr_q[AW-1:0]];

    assign s_if.o_ready = !full;
    assign push         = s_if.i_valid && !full;

    always_comb begin
        wr_ptr_d = wr_ptr_q + (AW+1)'(push);
        rd_ptr_d = rd_ptr_q + (AW+1)'(pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= s_if.i_value;
        end
    end

    // ---------------- strobe sequencer ----------------
    state_e                  state_q;
    logic [CW-1:0]           cnt_q;
    logic [BITS_PER_TAP-1:0] value_q;
    logic                    dclk_q;
    logic [15:0]             sent_q;
    logic                    cnt_done;

    assign cnt_done = (cnt_q == '0);
    // A new sample is taken from IDLE or on the final LOW cycle (back-to-back).
    assign pop      = !empty && ((state_q == S_IDLE) || ((state_q == S_LOW) && cnt_done));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            value_q <= '0;
            dclk_q  <= 1'b0;
            sent_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (pop) begin
                        value_q <= head;
                        cnt_q   <= CW'(SETUP_CYCLES - 1);
                        state_q <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (cnt_done) begin
                        dclk_q  <= 1'b1;
                        cnt_q   <= CW'(HIGH_CYCLES - 1);
                        state_q <= S_HIGH;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                S_HIGH: begin
                    if (cnt_done) begin
                        dclk_q  <= 1'b0;
                        sent_q  <= sent_q + 16'd1;
                        cnt_q   <= CW'(LOW_CYCLES - 1);
                        state_q <= S_LOW;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                S_LOW: begin
                    if (!cnt_done) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else if (pop) begin
                        value_q <= head;
                        cnt_q   <= CW'(SETUP_CYCLES - 1);
                        state_q <= S_SETUP;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    dclk_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign o_value      = value_q;
    assign o_data_clk   = dclk_q;
    assign o_sent_count = sent_q;
    assign o_busy       = (state_q != S_IDLE) || !empty;

endmodule

// File: tb/tb_sample_stream_tx.sv
// Scoreboard bench for sample_stream_tx: pushes record expected samples, a monitor acting
// as the tap-line receiver pops and compares on every o_data_clk rising edge.
module tb_sample_stream_tx;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sample_stream_tx_if #(.BITS_PER_TAP(8)) s_if ();

    logic [7:0]  o_value;
    logic        o_data_clk;
    logic        o_busy;
    logic [15:0] o_sent_count;

    sample_stream_tx #(
        .BITS_PER_TAP(8),
        .FIFO_DEPTH  (4),
        .SETUP_CYCLES(2),
        .HIGH_CYCLES (2),
        .LOW_CYCLES  (3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .s_if        (s_if),
        .o_value     (o_value),
        .o_data_clk  (o_data_clk),
        .o_busy      (o_busy),
        .o_sent_count(o_sent_count)
    );

    int         passed = 0;
    int         total  = 0;
    int         cyc    = 0;
    logic [7:0] exp_q[$];
    logic [7:0] rx_taps[$];
    int         rx_pulses = 0;
    int         rise_cyc[$];
    int         low_run = 0;
    logic       prev_dclk = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    endtask

    // Receiver / scoreboard: edge-detect the strobe and capture o_value.
    always @(negedge clk) begin
        if (rst) begin
            prev_dclk = 1'b0;
            low_run   = 0;
        end else begin
            if (o_data_clk && !prev_dclk) begin
                total++;
                if (low_run >= 3) passed++;
                else $display("FAIL low_before_rise: got %0d low cycles, expected >= 3", low_run);
                rx_taps.push_back(o_value);
                rx_pulses++;
                rise_cyc.push_back(cyc);
                total++;
                if (exp_q.size() == 0) begin
                    $display("FAIL scoreboard: strobe carried %0h, expected no strobe", o_value);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    if (o_value === e) passed++;
                    else $display("FAIL scoreboard: got %0h, expected %0h", o_value, e);
                end
            end
            if (o_data_clk) low_run = 0;
            else low_run++;
            prev_dclk = o_data_clk;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) tick();
        rst = 1'b0;
        exp_q.delete();
    endtask

    task automatic push(input logic [7:0] v, output int stalls);
        stalls = 0;
        s_if.i_valid = 1'b1;
        s_if.i_value = v;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (s_if.o_ready) begin
                exp_q.push_back(v);
                tick();
                s_if.i_valid = 1'b0;
                s_if.i_value = '0;
                return;
            end
            tick();
            stalls++;
        end
        s_if.i_valid = 1'b0;
        s_if.i_value = '0;
        total++;
        $display("FAIL push_timeout: value %0h not accepted, expected acceptance within 100 cycles", v);
    endtask

    task automatic wait_idle(input string nm);
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (!o_busy) return;
        end
        total++;
        $display("FAIL %s: o_busy still 1, expected 0 within 300 cycles", nm);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    logic [7:0] loop_vals [9] = '{8'h7F, 8'h80, 8'hC3, 8'h12, 8'hFE, 8'h00, 8'h5A, 8'hA5, 8'h01};

    initial begin
        int st;
        int st_sum;
        rst          = 1'b1;
        s_if.i_valid = 1'b0;
        s_if.i_value = '0;

        // Reset state
        repeat (2) tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_value", o_value, 8'h00);
        chk("rst_dclk", o_data_clk, 1'b0);
        chk("rst_count", o_sent_count, 16'd0);
        chk("rst_ready", s_if.o_ready, 1'b1);
        chk("rst_busy", o_busy, 1'b0);

        // Single sample latency and strobe shape
        tick();
        push(8'h5A, st);
        @(negedge clk); chk("single_t1_value", o_value, 8'h00);
        @(negedge clk); chk("single_t2_value", o_value, 8'h5A);
                        chk("single_t2_dclk", o_data_clk, 1'b0);
        @(negedge clk); chk("single_t3_dclk", o_data_clk, 1'b0);
        @(negedge clk); chk("single_t4_dclk", o_data_clk, 1'b1);
        @(negedge clk); chk("single_t5_dclk", o_data_clk, 1'b1);
        @(negedge clk); chk("single_t6_dclk", o_data_clk, 1'b0);
                        chk("single_count", o_sent_count, 16'd1);
        @(negedge clk);
        @(negedge clk); chk("single_t8_busy", o_busy, 1'b1);
        @(negedge clk); chk("single_t9_busy", o_busy, 1'b0);
                        chk("single_hold_value", o_value, 8'h5A);

        // Burst of 6: FIFO fills, 6th push refused on the pop cycle then accepted
        tick();
        do_reset(1);
        rise_cyc.delete();
        st_sum = 0;
        for (int i = 1; i <= 5; i++) begin
            push(8'(i), st);
            st_sum += st;
        end
        chk("burst_first5_stalls", st_sum, 0);
        chk("burst_full_ready", s_if.o_ready, 1'b0);
        push(8'h06, st);
        chk("burst_6th_stalls", st, 4);
        wait_idle("burst_idle");
        chk("burst_count", o_sent_count, 16'd6);
        chk("burst_rises", rise_cyc.size(), 6);
        for (int i = 1; i < 6 && i < rise_cyc.size(); i++)
            chk("burst_interval", rise_cyc[i] - rise_cyc[i-1], 7);

        // Reset while the strobe is high, with a sample still queued
        tick();
        push(8'h77, st);
        push(8'h78, st);
        for (int k = 0; k < 50 && !o_data_clk; k++) @(negedge clk);
        chk("midhigh_dclk_before", o_data_clk, 1'b1);
        #1 rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk("midhigh_dclk", o_data_clk, 1'b0);
        chk("midhigh_count", o_sent_count, 16'd0);
        chk("midhigh_value", o_value, 8'h00);
        chk("midhigh_busy", o_busy, 1'b0);
        chk("midhigh_ready", s_if.o_ready, 1'b1);
        tick();
        push(8'h3C, st);
        wait_idle("midhigh_idle");
        chk("midhigh_after_count", o_sent_count, 16'd1);
        chk("midhigh_after_value", o_value, 8'h3C);

        // Loopback into the receiver's tap vector
        rx_taps.delete();
        rx_pulses = 0;
        tick();
        for (int i = 0; i < 9; i++) push(loop_vals[i], st);
        wait_idle("loop_idle");
        chk("loop_pulses", rx_pulses, 9);
        for (int i = 0; i < 9 && i < rx_taps.size(); i++)
            chk("loop_tap", rx_taps[i], loop_vals[i]);
        chk("loop_count", o_sent_count, 16'd10);

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
